// File: rtl/ble_pkg.sv
// Shared types and constants for the BLE UART frame link.
package ble_pkg;

    typedef enum logic [1:0] {IDLE, SEND, TERM, DROP} ble_tx_state_t;

    localparam logic [7:0] BLE_TERM_NL = 8'h0A;

endpackage

// File: rtl/ble_rx_word_assembler.sv
// Packs received bytes little-endian into DATA_WIDTH words; drops a partial word after an idle timeout.
module ble_rx_word_assembler #(
    parameter int DATA_WIDTH       = 16,
    parameter int RX_TIMEOUT_TICKS = 2560
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  tick_in,
    input  logic                  byte_valid_in,
    input  logic [7:0]            byte_data_in,
    output logic                  param_valid_out,
    output logic [DATA_WIDTH-1:0] param_data_out,
    output logic                  rx_timeout_out
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = $clog2(BYTES) + 1;
    localparam int TW    = $clog2(RX_TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);
    localparam logic [TW-1:0] TMAX     = TW'(RX_TIMEOUT_TICKS);

    logic [CW-1:0]         count;
    logic [TW-1:0]         idle_ticks;
    logic [DATA_WIDTH-1:0] word;
    logic                  timeout_hit;

    assign timeout_hit    = (idle_ticks == TMAX) && (count != '0);
    assign param_data_out = word;

    // A byte arriving in the timeout cycle takes priority and keeps the partial word.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count           <= '0;
            idle_ticks      <= '0;
            word            <= '0;
            param_valid_out <= 1'b0;
            rx_timeout_out  <= 1'b0;
        end else begin
            param_valid_out <= 1'b0;
            rx_timeout_out  <= 1'b0;
            if (byte_valid_in) begin
                idle_ticks <= '0;
                for (int k = 0; k < BYTES; k++)
                    if (count == CW'(k))
                        word[8*k +: 8] <= byte_data_in;
                if (count == LAST_IDX) begin
                    count           <= '0;
                    param_valid_out <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                if (tick_in && (idle_ticks != TMAX))
                    idle_ticks <= idle_ticks + 1'b1;
                if (timeout_hit) begin
                    count          <= '0;
                    rx_timeout_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver sampling each bit at its centre; bytes with a bad stop bit are dropped.
module uart_rx #(
    parameter int SAMPLE_RATE = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       tick_in,
    input  logic       rx_in,
    output logic       valid_out,
    output logic [7:0] data_out
);

    localparam int TW = $clog2(SAMPLE_RATE) + 1;
    localparam logic [TW-1:0] HALF = TW'(SAMPLE_RATE / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(SAMPLE_RATE - 1);

    logic [1:0]    sync;
    logic          rx_s;
    logic          active;
    logic [3:0]    bit_pos;
    logic [TW-1:0] tcnt;
    logic [7:0]    sr;

    assign rx_s = sync[1];

    // bit_pos 0 is the start bit (checked at half a bit), 1..8 data, 9 stop.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync      <= 2'b11;
            active    <= 1'b0;
            bit_pos   <= '0;
            tcnt      <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            sync      <= {sync[0], rx_in};
            valid_out <= 1'b0;
            if (tick_in) begin
                if (!active) begin
                    if (!rx_s) begin
                        active  <= 1'b1;
                        bit_pos <= '0;
                        tcnt    <= '0;
                    end
                end else if (tcnt == ((bit_pos == 4'd0) ? HALF : FULL)) begin
                    tcnt    <= '0;
                    bit_pos <= bit_pos + 1'b1;
                    if (bit_pos == 4'd0) begin
                        if (rx_s)
                            active <= 1'b0;
                    end else if (bit_pos == 4'd9) begin
                        active <= 1'b0;
                        if (rx_s) begin
                            valid_out <= 1'b1;
                            data_out  <= sr;
                        end
                    end else begin
                        sr <= {rx_s, sr[7:1]};
                    end
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tick_generator.sv
// Free-running oversampling tick: one-cycle pulse SAMPLE_RATE times per UART bit.
module uart_tick_generator #(
    parameter int CLK_HZ      = 98_304_000,
    parameter int BAUDRATE_HZ = 115_200,
    parameter int SAMPLE_RATE = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick_out
);

    localparam int DIV = CLK_HZ / (BAUDRATE_HZ * SAMPLE_RATE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt      <= '0;
            tick_out <= 1'b0;
        end else if (cnt == DIV_LAST) begin
            cnt      <= '0;
            tick_out <= 1'b1;
        end else begin
            cnt      <= cnt + 1'b1;
            tick_out <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter. Starts a byte whenever enabled while idle; done pulses once at the end of the stop bit.
module uart_tx #(
    parameter int SAMPLE_RATE = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       tick_in,
    input  logic       en_in,
    input  logic [7:0] data_in,
    output logic       tx_out,
    output logic       done_out
);

    localparam int TW = $clog2(SAMPLE_RATE) + 1;
    localparam logic [TW-1:0] FULL = TW'(SAMPLE_RATE - 1);

    logic          busy;
    logic [3:0]    bit_pos;
    logic [TW-1:0] tcnt;
    logic [9:0]    frame;
    logic          start;
    logic          bit_end;

    // The done cycle blocks a restart so the caller can present the next byte first.
    assign start   = !busy && en_in && !done_out;
    assign bit_end = busy && tick_in && (tcnt == FULL);
    assign tx_out  = busy ? frame[0] : 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy     <= 1'b0;
            done_out <= 1'b0;
            bit_pos  <= '0;
            tcnt     <= '0;
        end else begin
            done_out <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                bit_pos <= '0;
                tcnt    <= '0;
            end else if (busy && tick_in) begin
                if (tcnt == FULL) begin
                    tcnt <= '0;
                    if (bit_pos == 4'd9) begin
                        busy     <= 1'b0;
                        done_out <= 1'b1;
                    end else begin
                        bit_pos <= bit_pos + 1'b1;
                    end
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (start)
            frame <= {1'b1, data_in, 1'b0};
        else if (bit_end)
            frame <= {1'b1, frame[9:1]};
    end

endmodule

// File: rtl/ble_frame_link.sv
// BLE UART link: frame-gated serialiser of feature words to little-endian bytes, plus RX word reassembly.
module ble_frame_link
    import ble_pkg::*;
#(
    parameter int         BAUDRATE_HZ      = 115_200,
    parameter int         CLK_HZ           = 98_304_000,
    parameter int         SAMPLE_RATE      = 16,
    parameter int         DATA_WIDTH       = 16,
    parameter bit         TERM_EN          = 1'b1,
    parameter logic [7:0] TERM_BYTE        = BLE_TERM_NL,
    parameter int         RX_TIMEOUT_TICKS = 16 * SAMPLE_RATE * 10
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_enable_in,
    input  logic [DATA_WIDTH-1:0] feature_data_in,
    input  logic                  feature_valid_in,
    input  logic                  feature_last_in,
    output logic                  feature_ready_out,
    output logic [15:0]           frames_sent_out,
    output logic [15:0]           frames_dropped_out,
    output logic                  ble_valid_out,
    output logic [7:0]            ble_data_out,
    output logic                  param_valid_out,
    output logic [DATA_WIDTH-1:0] param_data_out,
    output logic                  rx_timeout_out,
    input  logic                  ble_uart_rx_in,
    output logic                  ble_uart_tx_out
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IW    = $clog2(BYTES) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    ble_tx_state_t         state, state_n;
    logic                  mid_frame;
    logic                  last_q;
    logic [IW-1:0]         byte_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  tick, tx_en, tx_done;
    logic [7:0]            tx_data;
    logic                  accept, load, shift_en, inc_sent, inc_drop;

    assign feature_ready_out = !rst_in && ((state == IDLE) || (state == DROP));
    assign accept            = feature_valid_in && feature_ready_out;

    uart_tick_generator #(
        .CLK_HZ      (CLK_HZ),
        .BAUDRATE_HZ (BAUDRATE_HZ),
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_tick (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .tick_out (tick)
    );

    uart_tx #(.SAMPLE_RATE(SAMPLE_RATE)) u_tx (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .tick_in  (tick),
        .en_in    (tx_en),
        .data_in  (tx_data),
        .tx_out   (ble_uart_tx_out),
        .done_out (tx_done)
    );

    uart_rx #(.SAMPLE_RATE(SAMPLE_RATE)) u_rx (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .tick_in   (tick),
        .rx_in     (ble_uart_rx_in),
        .valid_out (ble_valid_out),
        .data_out  (ble_data_out)
    );

    ble_rx_word_assembler #(
        .DATA_WIDTH       (DATA_WIDTH),
        .RX_TIMEOUT_TICKS (RX_TIMEOUT_TICKS)
    ) u_asm (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tick_in         (tick),
        .byte_valid_in   (ble_valid_out),
        .byte_data_in    (ble_data_out),
        .param_valid_out (param_valid_out),
        .param_data_out  (param_data_out),
        .rx_timeout_out  (rx_timeout_out)
    );

    // Enable is only consulted on a frame's first word, so frames go out or vanish whole.
    always_comb begin
        state_n  = state;
        tx_en    = 1'b0;
        tx_data  = shift[7:0];
        load     = 1'b0;
        shift_en = 1'b0;
        inc_sent = 1'b0;
        inc_drop = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (frame_enable_in || mid_frame) begin
                        load    = 1'b1;
                        state_n = SEND;
                    end else if (feature_last_in) begin
                        inc_drop = 1'b1;
                    end else begin
                        state_n = DROP;
                    end
                end
            end
            DROP: begin
                if (accept && feature_last_in) begin
                    inc_drop = 1'b1;
                    state_n  = IDLE;
                end
            end
            SEND: begin
                tx_en = 1'b1;
                if (tx_done) begin
                    if (byte_idx != LAST_IDX) begin
                        shift_en = 1'b1;
                    end else if (last_q) begin
                        if (TERM_EN) begin
                            state_n = TERM;
                        end else begin
                            inc_sent = 1'b1;
                            state_n  = IDLE;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            TERM: begin
                tx_en   = 1'b1;
                tx_data = TERM_BYTE;
                if (tx_done) begin
                    inc_sent = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= IDLE;
            mid_frame          <= 1'b0;
            last_q             <= 1'b0;
            byte_idx           <= '0;
            frames_sent_out    <= '0;
            frames_dropped_out <= '0;
        end else begin
            state <= state_n;
            if (accept)
                mid_frame <= !feature_last_in;
            if (load) begin
                last_q   <= feature_last_in;
                byte_idx <= '0;
            end else if (shift_en) begin
                byte_idx <= byte_idx + 1'b1;
            end
            if (inc_sent)
                frames_sent_out <= frames_sent_out + 16'd1;
            if (inc_drop)
                frames_dropped_out <= frames_dropped_out + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (load)
            shift <= feature_data_in;
        else if (shift_en)
            shift <= shift >> 8;
    end

endmodule

// File: tb/tb_ble_frame_link.sv
// Scoreboard bench: stimulus queues expected UART bytes/words, independent monitors decode and compare.
module tb_ble_frame_link;

    localparam int CLK_HZ   = 7_372_800;
    localparam int BAUD     = 115_200;
    localparam int SR       = 16;
    localparam int BIT_CLKS = (CLK_HZ / (BAUD * SR)) * SR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en0, fv0, fl0, rx0;
    logic [15:0] fd0;
    logic        rdy0, bv0, pv0, to0, tx0;
    logic [15:0] sent0, drop0, pd0;
    logic [7:0]  bd0;

    logic        en1, fv1, fl1, rx1;
    logic [23:0] fd1;
    logic        rdy1, bv1, pv1, to1, tx1;
    logic [15:0] sent1, drop1;
    logic [23:0] pd1;
    logic [7:0]  bd1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_timeout = 0;
    int waited;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  bq[$];
    logic [15:0] pq[$];
    bit          ign0 = 1'b0;
    logic [7:0]  b0, b1;
    logic        s0, s1;
    logic        prev_bv = 1'b0;

    ble_frame_link #(
        .BAUDRATE_HZ(BAUD), .CLK_HZ(CLK_HZ), .SAMPLE_RATE(SR),
        .DATA_WIDTH(16), .TERM_EN(1'b1), .TERM_BYTE(8'h0A)
    ) u0 (
        .clk_in(clk), .rst_in(rst), .frame_enable_in(en0),
        .feature_data_in(fd0), .feature_valid_in(fv0), .feature_last_in(fl0),
        .feature_ready_out(rdy0), .frames_sent_out(sent0), .frames_dropped_out(drop0),
        .ble_valid_out(bv0), .ble_data_out(bd0), .param_valid_out(pv0),
        .param_data_out(pd0), .rx_timeout_out(to0),
        .ble_uart_rx_in(rx0), .ble_uart_tx_out(tx0)
    );

    ble_frame_link #(
        .BAUDRATE_HZ(BAUD), .CLK_HZ(CLK_HZ), .SAMPLE_RATE(SR),
        .DATA_WIDTH(24), .TERM_EN(1'b0)
    ) u1 (
        .clk_in(clk), .rst_in(rst), .frame_enable_in(en1),
        .feature_data_in(fd1), .feature_valid_in(fv1), .feature_last_in(fl1),
        .feature_ready_out(rdy1), .frames_sent_out(sent1), .frames_dropped_out(drop1),
        .ble_valid_out(bv1), .ble_data_out(bd1), .param_valid_out(pv1),
        .param_data_out(pd1), .rx_timeout_out(to1),
        .ble_uart_rx_in(rx1), .ble_uart_tx_out(tx1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    task automatic capture(input bit which, output logic [7:0] b, output logic stop);
        repeat (BIT_CLKS + BIT_CLKS / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b[i] = which ? tx1 : tx0;
            repeat (BIT_CLKS) @(negedge clk);
        end
        stop = which ? tx1 : tx0;
    endtask

    task automatic send0(input logic [15:0] d, input logic l, output int w);
        @(negedge clk);
        fd0 = d; fl0 = l; fv0 = 1'b1; w = 0;
        while (!rdy0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("send0_ready", rdy0, 1);
        @(negedge clk);
        fv0 = 1'b0;
    endtask

    task automatic send1(input logic [23:0] d, input logic l);
        int w;
        @(negedge clk);
        fd1 = d; fl1 = l; fv1 = 1'b1; w = 0;
        while (!rdy1 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("send1_ready", rdy1, 1);
        @(negedge clk);
        fv1 = 1'b0;
    endtask

    task automatic drive_rx(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx0 = f[i];
            repeat (BIT_CLKS - 1) @(negedge clk);
        end
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic wait_drain(input bit which, input string name);
        int n;
        n = 0;
        while (((which ? q1.size() : q0.size()) != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, which ? q1.size() : q0.size(), 0);
        repeat (150) @(negedge clk);
    endtask

    always begin : mon_tx0
        @(negedge clk);
        if (tx0 === 1'b0) begin
            capture(1'b0, b0, s0);
            if (!ign0) begin
                if (q0.size() == 0) unexpected("tx0_byte", {b0, s0});
                else check("tx0_byte", {b0, s0}, {q0.pop_front(), 1'b1});
            end
        end
    end

    always begin : mon_tx1
        @(negedge clk);
        if (tx1 === 1'b0) begin
            capture(1'b1, b1, s1);
            if (q1.size() == 0) unexpected("tx1_byte", {b1, s1});
            else check("tx1_byte", {b1, s1}, {q1.pop_front(), 1'b1});
        end
    end

    always @(negedge clk) begin : mon_rx
        if (bv0 === 1'b1) begin
            if (bq.size() == 0) unexpected("rx_byte", bd0);
            else check("rx_byte", bd0, bq.pop_front());
        end
        if (pv0 === 1'b1) begin
            check("param_latency", prev_bv, 1);
            if (pq.size() == 0) unexpected("param_word", pd0);
            else check("param_word", pd0, pq.pop_front());
        end
        if (to0 === 1'b1) n_timeout++;
        prev_bv <= bv0;
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run did not complete, %0d compared so far", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1'b1;
        en0 = 1'b0; fv0 = 1'b0; fl0 = 1'b0; fd0 = '0; rx0 = 1'b1;
        en1 = 1'b0; fv1 = 1'b0; fl1 = 1'b0; fd1 = '0; rx1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", rdy0, 0);
        check("rst_tx_line", tx0, 1);
        check("rst_sent", sent0, 0);
        check("rst_dropped", drop0, 0);
        check("rst_rx_outs", {bv0, bd0, pv0, pd0, to0}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", rdy0, 1);

        // Two-word frame with terminator
        en0 = 1'b1;
        q0.push_back(8'h34); q0.push_back(8'h12); q0.push_back(8'hCD);
        q0.push_back(8'hAB); q0.push_back(8'h0A);
        send0(16'h1234, 1'b0, waited);
        send0(16'hABCD, 1'b1, waited);
        wait_drain(1'b0, "frame1_drain");
        check("frame1_sent", sent0, 1);

        // Disabled at frame start: whole frame dropped even after enable rises
        en0 = 1'b0;
        send0(16'h1111, 1'b0, waited);
        check("drop_w1_nowait", waited, 0);
        en0 = 1'b1;
        send0(16'h2222, 1'b0, waited);
        check("drop_w2_nowait", waited, 0);
        send0(16'h3333, 1'b1, waited);
        check("drop_w3_nowait", waited, 0);
        repeat (1500) @(negedge clk);
        check("drop_count", drop0, 1);
        check("drop_sent_unchanged", sent0, 1);

        // Enable falls mid-frame: frame still sent whole
        en0 = 1'b1;
        q0.push_back(8'h78); q0.push_back(8'h56); q0.push_back(8'h34);
        q0.push_back(8'h12); q0.push_back(8'h0A);
        send0(16'h5678, 1'b0, waited);
        en0 = 1'b0;
        send0(16'h1234, 1'b1, waited);
        wait_drain(1'b0, "frame3_drain");
        check("frame3_sent", sent0, 2);

        // 24-bit, no terminator
        en1 = 1'b1;
        q1.push_back(8'hEE); q1.push_back(8'hFF); q1.push_back(8'hC0);
        send1(24'hC0FFEE, 1'b1);
        wait_drain(1'b1, "u1_drain");
        repeat (BIT_CLKS * 12) @(negedge clk);
        check("u1_sent", sent1, 1);

        // RX reassembly and timeout
        bq.push_back(8'h78); bq.push_back(8'h56); pq.push_back(16'h5678);
        drive_rx(8'h78);
        drive_rx(8'h56);
        repeat (200) @(negedge clk);
        check("rx_word1_done", pq.size(), 0);
        bq.push_back(8'h11);
        drive_rx(8'h11);
        repeat (11000) @(negedge clk);
        check("rx_timeout_count", n_timeout, 1);
        bq.push_back(8'h22); bq.push_back(8'h33); pq.push_back(16'h3322);
        drive_rx(8'h22);
        drive_rx(8'h33);
        repeat (200) @(negedge clk);
        check("rx_word2_done", pq.size(), 0);
        check("rx_bytes_done", bq.size(), 0);
        check("rx_timeout_final", n_timeout, 1);

        // Reset during the second byte of a non-last word
        en0 = 1'b1;
        q0.push_back(8'hA5);
        send0(16'h5AA5, 1'b0, waited);
        repeat (960) @(negedge clk);
        ign0 = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_low", rdy0, 0);
        check("midrst_tx_line", tx0, 1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", rdy0, 1);
        check("midrst_counters", {sent0, drop0}, 0);
        en0 = 1'b0;
        send0(16'h0F0F, 1'b1, waited);
        repeat (5) @(negedge clk);
        check("midrst_mid_cleared", drop0, 1);
        repeat (1000) @(negedge clk);
        check("midrst_line_idle", tx0, 1);
        ign0 = 1'b0;

        check("q0_empty", q0.size(), 0);
        check("q1_empty", q1.size(), 0);
        check("u1_rx_quiet", {bv1, pv1, to1, bd1, pd1, drop1}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ble_frame_link.md
# ble_frame_link

Parametrised BLE UART link between the feature extractor and the PC. It serialises AXI-stream feature words of configurable width into little-endian UART bytes, a whole frame at a time, with an optional frame terminator. It also reassembles received UART bytes into parameter words, with inter-byte timeout recovery. It sits where the single-width feature/BLE bridge sits today, directly on the feature stream, with no internal FIFO.

## Interface
- `BAUDRATE_HZ`, 115_200, UART baud rate.
- `CLK_HZ`, 98_304_000, `clk_in` frequency.
- `SAMPLE_RATE`, 16, UART oversampling ticks per bit.
- `DATA_WIDTH`, 16, feature/parameter word width; a multiple of 8 in the range 8–64. `BYTES = DATA_WIDTH/8`.
- `TERM_EN`, 1, send a terminator byte after each transmitted frame.
- `TERM_BYTE`, 8'h0A, terminator value.
- `RX_TIMEOUT_TICKS`, 16*SAMPLE_RATE*10, UART ticks without a new byte before a partial RX word is discarded.

Ports:
- `clk_in` input 1: single system clock.
- `rst_in` input 1: synchronous, active-high reset.
- `frame_enable_in` input 1: transmit permission, sampled at frame start only.
- `feature_data_in` input DATA_WIDTH: feature word.
- `feature_valid_in` input 1: AXIS valid.
- `feature_last_in` input 1: marks the last word of a frame.
- `feature_ready_out` output 1: AXIS ready.
- `frames_sent_out` output 16: count of transmitted frames; wraps.
- `frames_dropped_out` output 16: count of discarded frames; wraps.
- `ble_valid_out` output 1: raw RX byte strobe.
- `ble_data_out` output 8: raw RX byte.
- `param_valid_out` output 1: one-cycle pulse, assembled word ready.
- `param_data_out` output DATA_WIDTH: assembled word.
- `rx_timeout_out` output 1: one-cycle pulse when a partial word is discarded.
- `ble_uart_rx_in` input 1: UART RX line.
- `ble_uart_tx_out` output 1: UART TX line.

## Operation
- **TX FSM states:** IDLE, SEND, TERM, DROP. Flag `mid_frame` is set after accepting a non-last word and cleared after accepting a last word.
- **IDLE:** `feature_ready_out` = 1.
  - On accept with (`frame_enable_in` | `mid_frame`): latch the word into the shift register, latch `last`, `byte_idx` = 0, go to SEND.
  - On accept with !`frame_enable_in` & !`mid_frame`: discard the word. If `last`, increment `frames_dropped_out` and stay in IDLE. Otherwise go to DROP.
- **DROP:** `feature_ready_out` = 1. Discard every word. On accepting `last`: increment the drop counter, go to IDLE. `frame_enable_in` is ignored.
- **SEND:** `feature_ready_out` = 0. uart_tx enable is high and its data is `shift[7:0]`. On uart_tx done:
  - If `byte_idx` < BYTES-1: shift right by 8 and increment `byte_idx`.
  - Else, if the latched `last` is set: go to TERM when `TERM_EN`; otherwise increment `frames_sent_out` and go to IDLE.
  - Else go to IDLE.
- **TERM:** send `TERM_BYTE`. On done: increment `frames_sent_out`, go to IDLE.
- **Frame gating:** a frame is either sent whole or dropped whole. A change of `frame_enable_in` mid-frame has no effect.
- **RX path:**
  - Every received byte pulses `ble_valid_out`/`ble_data_out`.
  - Bytes fill the word little-endian; byte k lands in bits [8k+7:8k].
  - After BYTES bytes: pulse `param_valid_out` and clear the byte count.
  - A tick counter resets on each byte. If it reaches `RX_TIMEOUT_TICKS` with count ≠ 0: clear the count and pulse `rx_timeout_out`.

## Timing
- **Reset values:** all outputs and counters 0; `ble_uart_tx_out` = 1; FSM in IDLE; `mid_frame` = 0. `feature_ready_out` is 0 during the reset cycle.
- **Reset mid-operation:** reset during SEND/TERM aborts the current byte. The line returns to 1 on the next cycle.
- **Ready timing:** `feature_ready_out` is combinational from state (IDLE or DROP). The word accepted in cycle N drives uart_tx enable in cycle N+1.
- **Inter-word gap:** exactly one idle cycle between the done of a word's last byte and the next word's first byte. No bytes are lost.
- **RX latency:** `param_valid_out` asserts the cycle after the final byte's `ble_valid_out`.
- **Simultaneous byte and timeout:** the byte wins; the count is not cleared.

## Structure
- Package `ble_pkg`:
  - `ble_tx_state_t` enum {IDLE, SEND, TERM, DROP}.
  - Default terminator constant `BLE_TERM_NL` = 8'h0A.
- Reuse the existing `uart_tick_generator`, `uart_tx` and `uart_rx`.
- Sub-module `ble_rx_word_assembler`: byte count, shift register and timeout counter.

## Test plan
- DATA_WIDTH=16, enable=1, frame 0x1234, 0xABCD(last) -> TX bytes 34 12 CD AB 0A; `frames_sent_out` = 1.
- Enable=0 at frame start, raised after word 1 of 3 -> zero bytes on TX; `frames_dropped_out` = 1; ready stays high throughout.
- Enable=1 at start, dropped after word 1 of 2 -> full frame plus 0A sent.
- DATA_WIDTH=24, TERM_EN=0, single word 0xC0FFEE(last) -> bytes EE FF C0; no terminator.
- RX bytes 0x78, 0x56 (16-bit) -> `param_data_out` = 0x5678, one `param_valid_out` pulse; then a lone 0x11 followed by silence -> `rx_timeout_out` pulse, and the next 0x22, 0x33 -> 0x3322.
- Reset asserted during byte 2 of a word -> TX line = 1, FSM IDLE, counters 0, ready = 1 after reset.
